// File: rtl/mem_lsu_pkg.sv
// mem_lsu shared types: access sizes, FSM states, align modes.
// Imported by the LSU top, its align helper and the bus interface users.
package mem_lsu_pkg;

  localparam int STRB_W = 8;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic {
    ALN_STORE = 1'b0,
    ALN_LOAD  = 1'b1
  } aln_mode_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic m;
    unique case (size)
      SIZE_B:  m = 1'b0;
      SIZE_H:  m = off[0];
      SIZE_W:  m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Single-outstanding req/gnt/rvalid data bus between LSU and memory.
// Signal suffixes are seen from the LSU (master) side.
interface mem_lsu_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();

  logic              mem_lsu_req_o;
  logic              mem_lsu_we_o;
  logic [ADDR_W-1:0] mem_lsu_bus_addr_o;
  logic [7:0]        mem_lsu_wstrb_o;
  logic [DATA_W-1:0] mem_lsu_bus_wdata_o;
  logic              mem_lsu_gnt_i;
  logic              mem_lsu_rvalid_i;
  logic [DATA_W-1:0] mem_lsu_bus_rdata_i;

  modport master (
    output mem_lsu_req_o,
    output mem_lsu_we_o,
    output mem_lsu_bus_addr_o,
    output mem_lsu_wstrb_o,
    output mem_lsu_bus_wdata_o,
    input  mem_lsu_gnt_i,
    input  mem_lsu_rvalid_i,
    input  mem_lsu_bus_rdata_i
  );

  modport slave (
    input  mem_lsu_req_o,
    input  mem_lsu_we_o,
    input  mem_lsu_bus_addr_o,
    input  mem_lsu_wstrb_o,
    input  mem_lsu_bus_wdata_o,
    output mem_lsu_gnt_i,
    output mem_lsu_rvalid_i,
    output mem_lsu_bus_rdata_i
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment: store shift + strobes, or load extract + extend.
// Purely combinational; mode_i picks the direction.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  aln_mode_e          mode_i,
  input  logic [1:0]         size_i,
  input  logic               uns_i,
  input  logic [2:0]         off_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [DATA_W-1:0]  rdata_i,
  output logic [STRB_W-1:0]  strb_o,
  output logic [DATA_W-1:0]  data_o
);

  logic [5:0]        sh;
  logic [DATA_W-1:0] lane;
  logic [STRB_W-1:0] mask;
  logic [DATA_W-1:0] ext;

  assign sh   = {off_i, 3'b000};
  assign lane = rdata_i >> sh;

  always_comb begin
    mask = 8'hFF;
    ext  = lane;
    unique case (size_i)
      SIZE_B: begin
        mask = 8'h01;
        ext  = {{(DATA_W-8){~uns_i & lane[7]}}, lane[7:0]};
      end
      SIZE_H: begin
        mask = 8'h03;
        ext  = {{(DATA_W-16){~uns_i & lane[15]}}, lane[15:0]};
      end
      SIZE_W: begin
        mask = 8'h0F;
        ext  = {{(DATA_W-32){~uns_i & lane[31]}}, lane[31:0]};
      end
      default: begin
        mask = 8'hFF;
        ext  = lane;
      end
    endcase
  end

  always_comb begin
    strb_o = '0;
    data_o = ext;
    if (mode_i == ALN_STORE) begin
      strb_o = mask << off_i;
      data_o = wdata_i << sh;
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus access in flight, stalls via ready.
// Non-memory ops and misaligned accesses complete without bus traffic.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_lsu_valid_i,
  output logic              mem_lsu_ready_o,
  input  logic              mem_lsu_load_i,
  input  logic              mem_lsu_store_i,
  input  logic [1:0]        mem_lsu_size_i,
  input  logic              mem_lsu_unsigned_i,
  input  logic [ADDR_W-1:0] mem_lsu_addr_i,
  input  logic [DATA_W-1:0] mem_lsu_wdata_i,
  output logic [DATA_W-1:0] mem_lsu_res_data_o,
  output logic              mem_lsu_done_o,
  output logic              mem_lsu_misalign_o,
  mem_lsu_if.master         bus
);

  state_e            state_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              load_q;
  logic [2:0]        off_q;
  logic              ready_q;
  logic              done_q;
  logic              mis_q;
  logic [DATA_W-1:0] res_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] baddr_q;
  logic [7:0]        strb_q;
  logic [DATA_W-1:0] bwdata_q;

  aln_mode_e         aln_mode;
  logic [1:0]        aln_size;
  logic              aln_uns;
  logic [2:0]        aln_off;
  logic [STRB_W-1:0] aln_strb;
  logic [DATA_W-1:0] aln_data;
  logic              is_mem;
  logic              mis;

  // IDLE aligns the incoming store; WAIT extracts load data from the bus.
  always_comb begin
    aln_mode = ALN_STORE;
    aln_size = mem_lsu_size_i;
    aln_uns  = mem_lsu_unsigned_i;
    aln_off  = mem_lsu_addr_i[2:0];
    if (state_q != S_IDLE) begin
      aln_size = size_q;
      aln_uns  = uns_q;
      aln_off  = off_q;
    end
    if (state_q == S_WAIT) aln_mode = ALN_LOAD;
  end

  mem_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .mode_i  (aln_mode),
    .size_i  (aln_size),
    .uns_i   (aln_uns),
    .off_i   (aln_off),
    .wdata_i (mem_lsu_wdata_i),
    .rdata_i (bus.mem_lsu_bus_rdata_i),
    .strb_o  (aln_strb),
    .data_o  (aln_data)
  );

  assign is_mem = mem_lsu_load_i | mem_lsu_store_i;
  assign mis    = misaligned(mem_lsu_size_i, mem_lsu_addr_i[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      size_q   <= '0;
      uns_q    <= 1'b0;
      load_q   <= 1'b0;
      off_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      res_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      strb_q   <= '0;
      bwdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mem_lsu_valid_i) begin
            size_q  <= mem_lsu_size_i;
            uns_q   <= mem_lsu_unsigned_i;
            load_q  <= mem_lsu_load_i;
            off_q   <= mem_lsu_addr_i[2:0];
            ready_q <= 1'b0;
            if (!is_mem) begin
              res_q   <= mem_lsu_addr_i;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (mis) begin
              res_q   <= '0;
              mis_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              req_q    <= 1'b1;
              we_q     <= mem_lsu_store_i;
              baddr_q  <= {mem_lsu_addr_i[ADDR_W-1:3], 3'b000};
              strb_q   <= aln_strb;
              bwdata_q <= aln_data;
              state_q  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_lsu_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_lsu_rvalid_i) begin
            res_q   <= load_q ? aln_data : '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_lsu_ready_o        = ready_q;
  assign mem_lsu_done_o         = done_q;
  assign mem_lsu_misalign_o     = mis_q;
  assign mem_lsu_res_data_o     = res_q;
  assign bus.mem_lsu_req_o      = req_q;
  assign bus.mem_lsu_we_o       = we_q;
  assign bus.mem_lsu_bus_addr_o = baddr_q;
  assign bus.mem_lsu_wstrb_o    = strb_q;
  assign bus.mem_lsu_bus_wdata_o = bwdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: bus driven by hand, results checked
// against a queue of expected writeback values.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic        load;
  logic        store;
  logic [1:0]  size;
  logic        uns;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] res;
  logic        done;
  logic        mis;

  mem_lsu_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  mem_lsu #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_lsu_valid_i    (valid),
    .mem_lsu_ready_o    (ready),
    .mem_lsu_load_i     (load),
    .mem_lsu_store_i    (store),
    .mem_lsu_size_i     (size),
    .mem_lsu_unsigned_i (uns),
    .mem_lsu_addr_i     (addr),
    .mem_lsu_wdata_i    (wdata),
    .mem_lsu_res_data_o (res),
    .mem_lsu_done_o     (done),
    .mem_lsu_misalign_o (mis),
    .bus                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   nvec;
  int   nerr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic u, input logic [63:0] a,
                       input logic [63:0] wd);
    valid = 1'b1;
    load  = ld;
    store = st;
    size  = sz;
    uns   = u;
    addr  = a;
    wdata = wd;
    step();
    valid = 1'b0;
  endtask

  task automatic expect_res(input logic [63:0] r, input logic m);
    exp_t e;
    e.res = r;
    e.mis = m;
    sb.push_back(e);
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, ".done"}, {63'd0, done}, 64'd1);
    nvec++;
    assert (sb.size() > 0) else begin
      nerr++;
      $error("FAIL %s.sb: observed empty queue expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".res"}, res, e.res);
      chk({tag, ".mis"}, {63'd0, mis}, {63'd0, e.mis});
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    valid = 1'b0;
    load  = 1'b0;
    store = 1'b0;
    size  = 2'd0;
    uns   = 1'b0;
    addr  = '0;
    wdata = '0;
    bus.mem_lsu_gnt_i       = 1'b0;
    bus.mem_lsu_rvalid_i    = 1'b0;
    bus.mem_lsu_bus_rdata_i = '0;
    step();
    step();
    chk("rst.ready", {63'd0, ready}, 64'd1);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.req", {63'd0, bus.mem_lsu_req_o}, 64'd0);
    chk("rst.res", res, 64'd0);
    rst_n = 1'b1;
    step();

    // non-memory pass-through
    expect_res(64'h1234_5678_9ABC_DEF0, 1'b0);
    issue(1'b0, 1'b0, 2'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, '0);
    check_done("alu");
    chk("alu.req", {63'd0, bus.mem_lsu_req_o}, 64'd0);
    chk("alu.rdy", {63'd0, ready}, 64'd0);
    step();
    chk("alu.done_clr", {63'd0, done}, 64'd0);
    chk("alu.rdy_back", {63'd0, ready}, 64'd1);
    chk("alu.hold", res, 64'h1234_5678_9ABC_DEF0);

    // LB signed then unsigned
    for (int u = 0; u < 2; u++) begin
      expect_res(u == 0 ? 64'hFFFF_FFFF_FFFF_FF8F : 64'h8F, 1'b0);
      issue(1'b1, 1'b0, 2'd0, u[0], 64'h8000_0003, '0);
      chk("lb.req", {63'd0, bus.mem_lsu_req_o}, 64'd1);
      chk("lb.we", {63'd0, bus.mem_lsu_we_o}, 64'd0);
      chk("lb.baddr", bus.mem_lsu_bus_addr_o, 64'h8000_0000);
      chk("lb.strb", {56'd0, bus.mem_lsu_wstrb_o}, 64'h08);
      bus.mem_lsu_gnt_i = 1'b1;
      step();
      bus.mem_lsu_gnt_i       = 1'b0;
      chk("lb.req_off", {63'd0, bus.mem_lsu_req_o}, 64'd0);
      bus.mem_lsu_rvalid_i    = 1'b1;
      bus.mem_lsu_bus_rdata_i = 64'h0000_0000_8F00_0000;
      step();
      bus.mem_lsu_rvalid_i    = 1'b0;
      check_done(u == 0 ? "lb" : "lbu");
      step();
    end

    // SH lanes 6..7
    expect_res(64'd0, 1'b0);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hABCD);
    chk("sh.strb", {56'd0, bus.mem_lsu_wstrb_o}, 64'hC0);
    chk("sh.wdata", bus.mem_lsu_bus_wdata_o, 64'hABCD_0000_0000_0000);
    chk("sh.we", {63'd0, bus.mem_lsu_we_o}, 64'd1);
    chk("sh.baddr", bus.mem_lsu_bus_addr_o, 64'h8000_0000);
    bus.mem_lsu_gnt_i = 1'b1;
    step();
    bus.mem_lsu_gnt_i    = 1'b0;
    bus.mem_lsu_rvalid_i = 1'b1;
    bus.mem_lsu_bus_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.mem_lsu_rvalid_i = 1'b0;
    check_done("sh");
    step();

    // LD with grant stall, then a late response
    expect_res(64'h0123_4567_89AB_CDEF, 1'b0);
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0010, '0);
    for (int i = 0; i < 4; i++) begin
      chk("ld.stall_req", {63'd0, bus.mem_lsu_req_o}, 64'd1);
      chk("ld.stall_addr", bus.mem_lsu_bus_addr_o, 64'h8000_0010);
      chk("ld.stall_we", {63'd0, bus.mem_lsu_we_o}, 64'd0);
      chk("ld.stall_rdy", {63'd0, ready}, 64'd0);
      step();
    end
    chk("ld.strb", {56'd0, bus.mem_lsu_wstrb_o}, 64'hFF);
    bus.mem_lsu_gnt_i = 1'b1;
    step();
    bus.mem_lsu_gnt_i = 1'b0;
    step();
    chk("ld.wait_done", {63'd0, done}, 64'd0);
    chk("ld.wait_rdy", {63'd0, ready}, 64'd0);
    bus.mem_lsu_rvalid_i    = 1'b1;
    bus.mem_lsu_bus_rdata_i = 64'h0123_4567_89AB_CDEF;
    step();
    bus.mem_lsu_rvalid_i = 1'b0;
    check_done("ld");
    step();

    // LH unsigned from upper half-lane with MSB set
    expect_res(64'h0000_0000_0000_F00D, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b1, 64'h8000_0024, '0);
    bus.mem_lsu_gnt_i = 1'b1;
    step();
    bus.mem_lsu_gnt_i       = 1'b0;
    bus.mem_lsu_rvalid_i    = 1'b1;
    bus.mem_lsu_bus_rdata_i = 64'h1111_F00D_2222_3333;
    step();
    bus.mem_lsu_rvalid_i = 1'b0;
    check_done("lhu");
    step();

    // misaligned LW
    expect_res(64'd0, 1'b1);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0002, '0);
    check_done("mis");
    chk("mis.req", {63'd0, bus.mem_lsu_req_o}, 64'd0);
    step();
    chk("mis.clr", {63'd0, mis}, 64'd0);
    chk("mis.rdy", {63'd0, ready}, 64'd1);
    expect_res(64'h55, 1'b0);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h55, '0);
    check_done("mis.next");
    step();

    // reset while waiting for the response
    issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0008, '0);
    bus.mem_lsu_gnt_i = 1'b1;
    step();
    bus.mem_lsu_gnt_i = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst2.req", {63'd0, bus.mem_lsu_req_o}, 64'd0);
    chk("rst2.ready", {63'd0, ready}, 64'd1);
    chk("rst2.res", res, 64'd0);
    #1;
    rst_n = 1'b1;
    bus.mem_lsu_rvalid_i    = 1'b1;
    bus.mem_lsu_bus_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    bus.mem_lsu_rvalid_i = 1'b0;
    chk("rst2.nodone", {63'd0, done}, 64'd0);
    chk("rst2.rdy", {63'd0, ready}, 64'd1);
    step();
    chk("rst2.nodone2", {63'd0, done}, 64'd0);
    chk("rst2.res2", res, 64'd0);
    chk("sb.empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit in the MEM stage of the RV64 five-stage pipeline.
- Consumes the EX-stage result, which is either an effective address or a plain ALU result. Drives a single-outstanding request/grant/response data bus.
- Returns aligned, sign- or zero-extended load data, or passes the ALU result through.
- Stalls the pipeline via a valid/ready handshake while a bus access is in flight.

Parameters:
- DATA_W, 64, width of data path and of bus data.
- ADDR_W, 64, width of effective address.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- mem_lsu_valid_i  input  1  EX result and controls are valid.
- mem_lsu_ready_o  output  1  LSU accepts a new operation this cycle.
- mem_lsu_load_i  input  1  operation is a load.
- mem_lsu_store_i  input  1  operation is a store. Never asserted together with load.
- mem_lsu_size_i  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- mem_lsu_unsigned_i  input  1  zero-extend load data (LBU/LHU/LWU).
- mem_lsu_addr_i  input  ADDR_W  EX result: effective address, or ALU result for non-memory operations.
- mem_lsu_wdata_i  input  DATA_W  store data taken from rs2, LSB-justified.
- mem_lsu_res_data_o  output  DATA_W  result delivered to writeback.
- mem_lsu_done_o  output  1  one-cycle pulse: res_data/misalign are valid.
- mem_lsu_misalign_o  output  1  misaligned-access exception; qualified by done.
- mem_lsu_req_o  output  1  bus request.
- mem_lsu_we_o  output  1  bus write enable.
- mem_lsu_bus_addr_o  output  ADDR_W  doubleword-aligned bus address; bits [2:0] are always 0.
- mem_lsu_wstrb_o  output  8  byte-lane strobes.
- mem_lsu_bus_wdata_o  output  DATA_W  lane-shifted store data.
- mem_lsu_gnt_i  input  1  bus accepted the request.
- mem_lsu_rvalid_i  input  1  response valid: read data for loads, write acknowledge for stores.
- mem_lsu_bus_rdata_i  input  DATA_W  read data, full doubleword.

Behaviour:
- Reset state: FSM in IDLE. All outputs are 0 except ready_o = 1. Internal registers are cleared.
- FSM states and transitions:
  - IDLE: ready_o = 1. An operation is accepted when valid_i && ready_o, and its inputs are registered (addr, size, unsigned, load/store, wdata).
    - Non-memory operation goes to DONE, with res_data = addr.
    - Misaligned access goes to DONE, with misalign_o = 1, res_data = 0 and no bus activity. Misaligned means addr[0] != 0 for half, addr[1:0] != 0 for word, addr[2:0] != 0 for double.
    - Otherwise go to REQ.
  - REQ:
    - req_o = 1.
    - we_o = store.
    - bus_addr = {addr[63:3], 3'b0}.
    - wstrb is a size mask (0x01 / 0x03 / 0x0F / 0xFF) shifted left by addr[2:0].
    - bus_wdata = wdata shifted left by 8*addr[2:0].
    - All of these stay stable until gnt_i. gnt_i high moves to WAIT.
  - WAIT: req_o = 0. On rvalid_i:
    - For a load, extract the lane at 8*addr[2:0], sign- or zero-extend it to 64 bits, and register it into res_data.
    - For a store, res_data = 0.
    - Go to DONE.
  - DONE: done_o = 1 for exactly one cycle, ready_o = 0. Return to IDLE.
- ready_o is 0 in REQ, WAIT and DONE. Upstream holds its inputs, but the LSU uses only the registered copy.
- Latency:
  - Non-memory or misaligned: done 1 cycle after accept.
  - Memory access: done 1 cycle after rvalid. Minimum 3 cycles (accept → REQ with gnt → WAIT with rvalid → DONE).
- Exactly one request outstanding at a time. rvalid_i arrives no earlier than the cycle after gnt_i.
- gnt_i and rvalid_i outside REQ/WAIT are ignored; no state change.
- res_data_o holds its last value between done pulses. misalign_o clears when leaving DONE.
- Asynchronous reset mid-operation: return immediately to IDLE with req_o = 0 and the in-flight access abandoned. A late rvalid after reset is ignored.

Decomposition:
- Shared defines header gains:
  - LSU size encodings (SIZE_B/H/W/D).
  - FSM state encodings (2-bit: IDLE, REQ, WAIT, DONE).
  - STRB_BUS width macro.
- One combinational sub-module, mem_lsu_align: store lane shift + strobe generation, and load lane extract + sign/zero extension, parameterised by size, unsigned and addr[2:0]. Reused for both directions with a mode select.

Test Plan:
- Non-memory pass-through: valid with addr = 0x1234_5678_9ABC_DEF0, load = store = 0 → done 1 cycle later, res_data = 0x1234_5678_9ABC_DEF0, req_o never asserted.
- LB sign-extension: load byte, addr 0x8000_0003, bus_rdata = 0x0000_0000_8F00_0000, gnt same cycle, rvalid next cycle → bus_addr = 0x8000_0000, res_data = 0xFFFF_FFFF_FFFF_FF8F. Repeat with unsigned → 0x8F.
- SH lanes: store half, addr 0x8000_0006, wdata = 0xABCD → wstrb = 0xC0, bus_wdata[63:48] = 0xABCD, we_o = 1. done follows the rvalid ack, res_data = 0.
- Grant stall: LD at 0x8000_0010, gnt_i held low 4 cycles → req/addr/we stable throughout, ready_o = 0, done exactly 1 cycle after rvalid.
- Misaligned: LW at 0x8000_0002 → done + misalign_o = 1 one cycle after accept, req_o never asserted, next operation accepted normally.
- Reset mid-op: assert rst_n low in WAIT, then pulse rvalid after release → outputs return to reset values, no done pulse, ready_o = 1.
